// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath widths, ALU operation codes and the ID/EX register layout
package cpu_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SLL = 4'b0110,
    ALU_SRL = 4'b0111,
    ALU_SRA = 4'b1000,
    ALU_SLT = 4'b1001
  } alu_sel_e;

  // One instruction as held in the ID/EX register.
  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rs1_addr;
    logic [RA_W-1:0] rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rs2_used;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            use_imm;
    logic            use_pc;
    alu_sel_e        alu_sel;
    logic [RA_W-1:0] rd_addr;
    logic            reg_write;
    logic            is_load;
  } id_ex_t;

  // True when a writeback port targets this source register; x0 is never a match.
  function automatic logic fwd_hit(input logic en, input logic [RA_W-1:0] rd,
                                   input logic [RA_W-1:0] src);
    return en && (rd == src) && (src != '0);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - per-source operand forwarding, MEM over WB over registered data
module fwd_mux
  import cpu_pkg::*;
(
  input  logic [RA_W-1:0] src_addr_i,
  input  logic [XLEN-1:0] reg_data_i,
  input  logic            mem_en_i,
  input  logic [RA_W-1:0] mem_rd_i,
  input  logic [XLEN-1:0] mem_data_i,
  input  logic            wb_en_i,
  input  logic [RA_W-1:0] wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic [XLEN-1:0] data_o
);

  // The younger MEM result shadows the older WB result for the same register.
  always_comb begin
    data_o = reg_data_i;
    if (fwd_hit(mem_en_i, mem_rd_i, src_addr_i)) begin
      data_o = mem_data_i;
    end else if (fwd_hit(wb_en_i, wb_rd_i, src_addr_i)) begin
      data_o = wb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX register with load-use interlock and operand forwarding to the ALU
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [RA_W-1:0] id_rs1_addr,
  input  logic [RA_W-1:0] id_rs2_addr,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic            id_rs2_used,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_pc,
  input  logic            id_use_imm,
  input  logic            id_use_pc,
  input  logic [3:0]      id_alu_sel,
  input  logic [RA_W-1:0] id_rd_addr,
  input  logic            id_reg_write,
  input  logic            id_is_load,
  input  logic            ex_stall,
  input  logic            flush,
  input  logic            mem_fwd_en,
  input  logic [RA_W-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic            wb_fwd_en,
  input  logic [RA_W-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0] wb_fwd_data,
  output logic            ex_valid,
  output logic [XLEN-1:0] operand_0,
  output logic [XLEN-1:0] operand_1,
  output logic [3:0]      ALU_Sel,
  output logic [XLEN-1:0] ex_rs2_fwd,
  output logic [RA_W-1:0] ex_rd_addr,
  output logic            ex_reg_write,
  output logic            ex_is_load
);

  id_ex_t          ex_q, ex_d;
  logic            hazard;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  // A load in EX cannot forward until MEM, so a consumer in decode must wait one cycle.
  assign hazard = ex_q.valid && ex_q.is_load && (ex_q.rd_addr != '0) &&
                  ((ex_q.rd_addr == id_rs1_addr) ||
                   (id_rs2_used && (ex_q.rd_addr == id_rs2_addr)));

  assign id_ready = !ex_stall && !hazard;

  // Next ID/EX contents: flush, then stall (with WB refresh), then bubble, then load.
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d.valid = 1'b0;
    end else if (ex_stall) begin
      // WB retires while we wait; capture it now so the value survives its departure.
      if (fwd_hit(wb_fwd_en, wb_fwd_rd, ex_q.rs1_addr)) begin
        ex_d.rs1_data = wb_fwd_data;
      end
      // rs2 data only matters to instructions that actually read rs2.
      if (ex_q.rs2_used && fwd_hit(wb_fwd_en, wb_fwd_rd, ex_q.rs2_addr)) begin
        ex_d.rs2_data = wb_fwd_data;
      end
    end else if (hazard) begin
      ex_d.valid = 1'b0;
    end else begin
      ex_d.valid     = id_valid;
      ex_d.rs1_addr  = id_rs1_addr;
      ex_d.rs2_addr  = id_rs2_addr;
      ex_d.rs1_data  = id_rs1_data;
      ex_d.rs2_data  = id_rs2_data;
      ex_d.rs2_used  = id_rs2_used;
      ex_d.imm       = id_imm;
      ex_d.pc        = id_pc;
      ex_d.use_imm   = id_use_imm;
      ex_d.use_pc    = id_use_pc;
      ex_d.alu_sel   = alu_sel_e'(id_alu_sel);
      ex_d.rd_addr   = id_rd_addr;
      ex_d.reg_write = id_reg_write;
      ex_d.is_load   = id_is_load;
    end
  end

  // ID/EX register; reset clears every field so the ALU sees ADD of zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  fwd_mux u_fwd_rs1 (
    .src_addr_i (ex_q.rs1_addr),
    .reg_data_i (ex_q.rs1_data),
    .mem_en_i   (mem_fwd_en),
    .mem_rd_i   (mem_fwd_rd),
    .mem_data_i (mem_fwd_data),
    .wb_en_i    (wb_fwd_en),
    .wb_rd_i    (wb_fwd_rd),
    .wb_data_i  (wb_fwd_data),
    .data_o     (fwd_rs1)
  );

  fwd_mux u_fwd_rs2 (
    .src_addr_i (ex_q.rs2_addr),
    .reg_data_i (ex_q.rs2_data),
    .mem_en_i   (mem_fwd_en),
    .mem_rd_i   (mem_fwd_rd),
    .mem_data_i (mem_fwd_data),
    .wb_en_i    (wb_fwd_en),
    .wb_rd_i    (wb_fwd_rd),
    .wb_data_i  (wb_fwd_data),
    .data_o     (fwd_rs2)
  );

  assign operand_0    = ex_q.use_pc  ? ex_q.pc  : fwd_rs1;
  assign operand_1    = ex_q.use_imm ? ex_q.imm : fwd_rs2;
  assign ALU_Sel      = ex_q.alu_sel;
  assign ex_rs2_fwd   = fwd_rs2;
  assign ex_valid     = ex_q.valid;
  assign ex_rd_addr   = ex_q.rd_addr;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_is_load   = ex_q.is_load;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_ready;
  logic [4:0]  id_rs1_addr, id_rs2_addr;
  logic [31:0] id_rs1_data, id_rs2_data;
  logic        id_rs2_used;
  logic [31:0] id_imm, id_pc;
  logic        id_use_imm, id_use_pc;
  logic [3:0]  id_alu_sel;
  logic [4:0]  id_rd_addr;
  logic        id_reg_write, id_is_load;
  logic        ex_stall, flush;
  logic        mem_fwd_en, wb_fwd_en;
  logic [4:0]  mem_fwd_rd, wb_fwd_rd;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic        ex_valid;
  logic [31:0] operand_0, operand_1, ex_rs2_fwd;
  logic [3:0]  ALU_Sel;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write, ex_is_load;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_rs2_used(id_rs2_used),
    .id_imm(id_imm), .id_pc(id_pc), .id_use_imm(id_use_imm), .id_use_pc(id_use_pc),
    .id_alu_sel(id_alu_sel), .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .ex_stall(ex_stall), .flush(flush),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .ex_valid(ex_valid), .operand_0(operand_0), .operand_1(operand_1),
    .ALU_Sel(ALU_Sel), .ex_rs2_fwd(ex_rs2_fwd), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] r1, input logic [31:0] d1,
                          input logic [4:0] r2, input logic [31:0] d2, input logic used,
                          input logic [3:0] sel, input logic [4:0] rd, input logic ld);
    id_valid = v;  id_rs1_addr = r1; id_rs1_data = d1; id_rs2_addr = r2; id_rs2_data = d2;
    id_rs2_used = used; id_alu_sel = sel; id_rd_addr = rd; id_reg_write = 1'b1;
    id_is_load = ld; id_imm = 32'h0; id_pc = 32'h0; id_use_imm = 1'b0; id_use_pc = 1'b0;
  endtask

  task automatic fwd_off();
    mem_fwd_en = 1'b0; mem_fwd_rd = 5'd0; mem_fwd_data = 32'h0;
    wb_fwd_en  = 1'b0; wb_fwd_rd  = 5'd0; wb_fwd_data  = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ex_stall = 1'b0; flush = 1'b0; fwd_off();
    drive_id(1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 4'h0, 5'd0, 1'b0);
    id_reg_write = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", ex_valid); end
    total++; if (operand_0 !== 32'h0) begin bad++; $display("FAIL reset_op0 got=%h exp=0", operand_0); end
    total++; if (operand_1 !== 32'h0) begin bad++; $display("FAIL reset_op1 got=%h exp=0", operand_1); end
    total++; if (ALU_Sel !== 4'b0000) begin bad++; $display("FAIL reset_sel got=%b exp=0000", ALU_Sel); end
    total++; if (ex_reg_write !== 1'b0) begin bad++; $display("FAIL reset_rw got=%0b exp=0", ex_reg_write); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", id_ready); end
  endtask

  task automatic test_basic_add();
    drive_id(1'b1, 5'd1, 32'd5, 5'd2, 32'd7, 1'b1, 4'b0000, 5'd3, 1'b0);
    step();
    id_valid = 1'b0;
    #1;
    total++; if (operand_0 !== 32'd5) begin bad++; $display("FAIL add_op0 got=%h exp=5", operand_0); end
    total++; if (operand_1 !== 32'd7) begin bad++; $display("FAIL add_op1 got=%h exp=7", operand_1); end
    total++; if (ALU_Sel !== 4'b0000) begin bad++; $display("FAIL add_sel got=%b exp=0000", ALU_Sel); end
    total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%0b exp=1", ex_valid); end
    total++; if (ex_rd_addr !== 5'd3) begin bad++; $display("FAIL add_rd got=%0d exp=3", ex_rd_addr); end
    total++; if (ex_reg_write !== 1'b1) begin bad++; $display("FAIL add_rw got=%0b exp=1", ex_reg_write); end
  endtask

  task automatic test_fwd_priority();
    drive_id(1'b1, 5'd3, 32'h99, 5'd5, 32'h50, 1'b1, 4'b0001, 5'd6, 1'b0);
    step();
    id_valid = 1'b0;
    mem_fwd_en = 1'b1; mem_fwd_rd = 5'd3; mem_fwd_data = 32'h10;
    wb_fwd_en  = 1'b1; wb_fwd_rd  = 5'd3; wb_fwd_data  = 32'h20;
    #1;
    total++; if (operand_0 !== 32'h10) begin bad++; $display("FAIL fwd_mem_wins got=%h exp=10", operand_0); end
    total++; if (operand_1 !== 32'h50) begin bad++; $display("FAIL fwd_rs2_nomatch got=%h exp=50", operand_1); end
    mem_fwd_en = 1'b0;
    #1;
    total++; if (operand_0 !== 32'h20) begin bad++; $display("FAIL fwd_wb got=%h exp=20", operand_0); end
    wb_fwd_rd = 5'd5; wb_fwd_data = 32'h55;
    #1;
    total++; if (operand_1 !== 32'h55) begin bad++; $display("FAIL fwd_wb_rs2 got=%h exp=55", operand_1); end
    fwd_off();
    drive_id(1'b1, 5'd0, 32'hAB, 5'd0, 32'hCD, 1'b1, 4'b0000, 5'd6, 1'b0);
    step();
    id_valid = 1'b0;
    mem_fwd_en = 1'b1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'h10;
    wb_fwd_en  = 1'b1; wb_fwd_rd  = 5'd0; wb_fwd_data  = 32'h20;
    #1;
    total++; if (operand_0 !== 32'hAB) begin bad++; $display("FAIL fwd_x0_rs1 got=%h exp=ab", operand_0); end
    total++; if (ex_rs2_fwd !== 32'hCD) begin bad++; $display("FAIL fwd_x0_rs2 got=%h exp=cd", ex_rs2_fwd); end
    fwd_off();
  endtask

  task automatic test_load_use();
    drive_id(1'b1, 5'd1, 32'h100, 5'd0, 32'h0, 1'b0, 4'b0000, 5'd4, 1'b1);
    step();
    // rs2 matches the load but is not read: no interlock.
    drive_id(1'b1, 5'd1, 32'h1, 5'd4, 32'h0, 1'b0, 4'b0000, 5'd7, 1'b0);
    #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL lu_rs2_unused_ready got=%0b exp=1", id_ready); end
    drive_id(1'b1, 5'd4, 32'h0, 5'd2, 32'd7, 1'b1, 4'b0100, 5'd8, 1'b0);
    #1;
    total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL lu_ready got=%0b exp=0", id_ready); end
    step();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble got=%0b exp=0", ex_valid); end
    total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL lu_ready_after got=%0b exp=1", id_ready); end
    mem_fwd_en = 1'b1; mem_fwd_rd = 5'd4; mem_fwd_data = 32'h44;
    step();
    id_valid = 1'b0;
    #1;
    total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL lu_enter got=%0b exp=1", ex_valid); end
    total++; if (operand_0 !== 32'h44) begin bad++; $display("FAIL lu_op0 got=%h exp=44", operand_0); end
    total++; if (operand_1 !== 32'd7) begin bad++; $display("FAIL lu_op1 got=%h exp=7", operand_1); end
    total++; if (ALU_Sel !== 4'b0100) begin bad++; $display("FAIL lu_sel got=%b exp=0100", ALU_Sel); end
    fwd_off();
  endtask

  task automatic test_stall_refresh();
    drive_id(1'b1, 5'd6, 32'h61, 5'd7, 32'h70, 1'b1, 4'b0011, 5'd8, 1'b0);
    step();
    ex_stall = 1'b1;
    drive_id(1'b1, 5'd9, 32'hDEAD, 5'd10, 32'hBEEF, 1'b1, 4'b0010, 5'd11, 1'b0);
    wb_fwd_en = 1'b1; wb_fwd_rd = 5'd7; wb_fwd_data = 32'h33;
    #1;
    total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL st_ready got=%0b exp=0", id_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (operand_0 !== 32'h61) begin bad++; $display("FAIL st_op0[%0d] got=%h exp=61", i, operand_0); end
      total++; if (ALU_Sel !== 4'b0011) begin bad++; $display("FAIL st_sel[%0d] got=%b exp=0011", i, ALU_Sel); end
      total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL st_valid[%0d] got=%0b exp=1", i, ex_valid); end
    end
    ex_stall = 1'b0; id_valid = 1'b0; fwd_off();
    #1;
    total++; if (ex_rs2_fwd !== 32'h33) begin bad++; $display("FAIL st_rs2_refresh got=%h exp=33", ex_rs2_fwd); end
    total++; if (ex_rd_addr !== 5'd8) begin bad++; $display("FAIL st_rd got=%0d exp=8", ex_rd_addr); end
    step();
  endtask

  task automatic test_flush();
    drive_id(1'b1, 5'd1, 32'h1, 5'd2, 32'h2, 1'b1, 4'b0000, 5'd3, 1'b0);
    step();
    id_valid = 1'b0; ex_stall = 1'b1; flush = 1'b1;
    step();
    ex_stall = 1'b0; flush = 1'b0;
    #1;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL fl_stall got=%0b exp=0", ex_valid); end
    // Flush coinciding with a load-use hazard.
    drive_id(1'b1, 5'd1, 32'h0, 5'd0, 32'h0, 1'b0, 4'b0000, 5'd4, 1'b1);
    step();
    drive_id(1'b1, 5'd4, 32'h0, 5'd0, 32'h0, 1'b0, 4'b0100, 5'd5, 1'b0);
    flush = 1'b1;
    #1;
    total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL fl_haz_ready got=%0b exp=0", id_ready); end
    step();
    flush = 1'b0;
    #1;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL fl_haz_valid got=%0b exp=0", ex_valid); end
    step();
    id_valid = 1'b0;
    #1;
    total++; if (ex_valid !== 1'b1 || ALU_Sel !== 4'b0100) begin
      bad++; $display("FAIL fl_haz_reenter got=%0b/%b exp=1/0100", ex_valid, ALU_Sel); end
  endtask

  task automatic test_imm_pc();
    drive_id(1'b1, 5'd1, 32'h11, 5'd2, 32'h22, 1'b0, 4'b1001, 5'd3, 1'b0);
    id_use_imm = 1'b1; id_imm = 32'hFFFF_FFFC; id_use_pc = 1'b1; id_pc = 32'h100;
    step();
    id_valid = 1'b0;
    #1;
    total++; if (operand_1 !== 32'hFFFF_FFFC) begin bad++; $display("FAIL imm_op1 got=%h exp=fffffffc", operand_1); end
    total++; if (operand_0 !== 32'h100) begin bad++; $display("FAIL pc_op0 got=%h exp=100", operand_0); end
    total++; if (ex_rs2_fwd !== 32'h22) begin bad++; $display("FAIL imm_rs2fwd got=%h exp=22", ex_rs2_fwd); end
    total++; if (ALU_Sel !== 4'b1001) begin bad++; $display("FAIL imm_sel got=%b exp=1001", ALU_Sel); end
  endtask

  task automatic test_reset_mid_stall();
    drive_id(1'b1, 5'd1, 32'h5, 5'd2, 32'h6, 1'b1, 4'b0111, 5'd9, 1'b1);
    step();
    id_valid = 1'b0; ex_stall = 1'b1;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL rst_ms_valid got=%0b exp=0", ex_valid); end
    total++; if (operand_0 !== 32'h0 || operand_1 !== 32'h0) begin
      bad++; $display("FAIL rst_ms_ops got=%h/%h exp=0/0", operand_0, operand_1); end
    total++; if (ALU_Sel !== 4'b0000) begin bad++; $display("FAIL rst_ms_sel got=%b exp=0000", ALU_Sel); end
    total++; if (ex_rd_addr !== 5'd0 || ex_reg_write !== 1'b0 || ex_is_load !== 1'b0) begin
      bad++; $display("FAIL rst_ms_ctl got=%0d/%0b/%0b exp=0/0/0", ex_rd_addr, ex_reg_write, ex_is_load); end
    ex_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total++; if (ex_valid !== 1'b0 || id_ready !== 1'b1) begin
      bad++; $display("FAIL rst_ms_after got=%0b/%0b exp=0/1", ex_valid, id_ready); end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_fwd_priority();
    test_load_use();
    test_stall_refresh();
    test_flush();
    test_imm_pc();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Execute-side pipeline stage that feeds the ALU. It captures decoded instructions from the decode stage into the ID/EX register and detects load-use hazards. It resolves register operands through MEM- and WB-stage forwarding and presents `operand_0`, `operand_1` and `ALU_Sel` to the ALU. It supports downstream stall and branch flush.

## Interface
- `XLEN`, 32, datapath width
- `RA_W`, 5, register address width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `id_valid`  in  1  decode holds a valid instruction
- `id_ready`  out  1  stage accepts decode this cycle
- `id_rs1_addr`, `id_rs2_addr`  in  RA_W  source registers
- `id_rs1_data`, `id_rs2_data`  in  XLEN  register-file read data
- `id_rs2_used`  in  1  instruction reads rs2 (R-type/store/branch)
- `id_imm`, `id_pc`  in  XLEN  immediate, instruction PC
- `id_use_imm`  in  1  operand_1 = imm instead of rs2
- `id_use_pc`  in  1  operand_0 = pc instead of rs1
- `id_alu_sel`  in  4  ALU operation code
- `id_rd_addr`  in  RA_W  destination
- `id_reg_write`, `id_is_load`  in  1  writeback enable, load flag
- `ex_stall`  in  1  downstream hold
- `flush`  in  1  kill instruction in EX (taken branch)
- `mem_fwd_en`, `mem_fwd_rd`, `mem_fwd_data`  in  1/RA_W/XLEN  MEM-stage result
- `wb_fwd_en`, `wb_fwd_rd`, `wb_fwd_data`  in  1/RA_W/XLEN  WB-stage result
- `ex_valid`  out  1  EX holds a live instruction
- `operand_0`, `operand_1`  out  XLEN  ALU operands
- `ALU_Sel`  out  4  ALU operation
- `ex_rs2_fwd`  out  XLEN  forwarded rs2, used as store data
- `ex_rd_addr`, `ex_reg_write`, `ex_is_load`  out  RA_W/1/1  forwarded downstream

## Operation
- ID/EX register fields: valid, rs1/rs2 addr+data, rs2_used, imm, pc, use_imm, use_pc, alu_sel, rd, reg_write, is_load.
- Load-use hazard: `ex_valid & ex_is_load & ex_rd_addr!=0 & (ex_rd_addr==id_rs1_addr | (id_rs2_used & ex_rd_addr==id_rs2_addr))`.
- `id_ready = ~ex_stall & ~hazard`.
- Register update priority at each edge:
  - `flush`: valid←0.
  - `ex_stall`: hold all fields, except refresh the held rs1/rs2 data with the WB forward when `wb_fwd_en`, rd matches and rd≠0.
  - hazard: valid←0 (bubble); other fields don't-care.
  - Otherwise: load the decode fields; valid←`id_valid`.
- Forwarding (combinational, after the register), per source: MEM match → `mem_fwd_data`; else WB match → `wb_fwd_data`; else registered data. A match requires `*_fwd_en` and rd==src and src≠0. x0 is never forwarded.
- `operand_0` = use_pc ? pc : fwd_rs1.
- `operand_1` = use_imm ? imm : fwd_rs2.
- `ex_rs2_fwd` = fwd_rs2 always.
- When `ex_valid`=0, outputs still reflect register contents. Downstream gates on `ex_valid`.

## Timing
- Reset (asynchronous assert, synchronous release): all fields 0, so `ex_valid`=0, `ALU_Sel`=ADD (0000), operands 0, `ex_reg_write`=0. `id_ready`=1 after reset.
- Latency: instruction accepted at edge N is presented to the ALU during cycle N+1. The ALU result is combinational in the same cycle.
- Load-use: one bubble cycle. The dependent instruction enters on the following edge and takes its value from the MEM forward.
- `flush` with `ex_stall` in the same cycle: flush wins, valid←0.
- `flush` with hazard: valid←0. Decode is not accepted (`id_ready`=0).
- Reset mid-stall drops the held instruction.

## Structure
- Shared package `cpu_pkg`: `XLEN`, `RA_W`, ALU_Sel codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0110, SRL 0111, SRA 1000, SLT 1001.
- One sub-module, `fwd_mux`, instantiated twice (rs1, rs2). It implements the MEM>WB>register priority and the x0 exclusion.

## Test plan
- Reset, then ADD with rs1=x1(5), rs2=x2(7), no forwarding → cycle N+1: operand_0=5, operand_1=7, ALU_Sel=0000, ex_valid=1.
- rs1=x3 with mem_fwd(x3, 0x10) and wb_fwd(x3, 0x20) both active → operand_0=0x10. Same case with rs1=x0 → registered data, no forward.
- EX holds a load to x4 and decode reads x4 → id_ready=0 and one cycle of ex_valid=0. Next edge the instruction enters and operand_0=mem_fwd_data.
- ex_stall held for 3 cycles while wb_fwd updates the held rs2 (0x33) → outputs held and ex_rs2_fwd=0x33 after release.
- flush and ex_stall asserted together → next cycle ex_valid=0. id_use_imm with imm=-4 → operand_1=0xFFFFFFFC.
- rst_n asserted mid-stall → all outputs zero immediately, ex_valid=0.
